// File: rtl/mips_cpu_pkg.sv
// Shared types and helpers for the mips_cpu divider: FSM states, width constant
// and the sign/magnitude split used to prepare DIV/DIVU operands.
package mips_cpu_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    typedef struct packed {
        logic               sign;
        logic [DIV_WIDTH:0] mag;
    } abs_t;

    // One extra magnitude bit keeps |0x80000000| representable.
    function automatic abs_t abs_val(input logic [DIV_WIDTH-1:0] value, input logic is_signed);
        abs_t res;
        res.sign = is_signed & value[DIV_WIDTH-1];
        if (res.sign) begin
            res.mag = {(DIV_WIDTH+1){1'b0}} - {1'b1, value};
        end else begin
            res.mag = {1'b0, value};
        end
        return res;
    endfunction

endpackage

// File: rtl/mips_cpu_div_step.sv
// One restoring-division step: trial-subtract the divisor magnitude from the
// shifted partial remainder and either keep the difference or restore.
module mips_cpu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   shifted_rem,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH+1:0] diff_s;

    // Trial subtraction with a spare sign bit; a restored remainder always fits WIDTH bits.
    always_comb begin
        diff_s = {1'b0, shifted_rem} - {2'b00, divisor_mag};
        q_bit  = ~diff_s[WIDTH+1];
        if (q_bit) begin
            next_rem = diff_s[WIDTH-1:0];
        end else begin
            next_rem = shifted_rem[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mips_cpu_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: WIDTH iteration steps
// followed by one sign-fix cycle; quotient feeds LO, remainder feeds HI.
module mips_cpu_divider
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state_r;
    div_state_t       state_next_s;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic [CW-1:0]    count_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic             div_zero_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    abs_t             dvd_abs_s;
    abs_t             dsr_abs_s;
    logic [WIDTH-1:0] next_rem_s;
    logic             q_bit_s;
    logic             unused_s;

    assign dvd_abs_s = abs_val(dividend, is_signed);
    assign dsr_abs_s = abs_val(divisor, is_signed);
    // The top magnitude bit is always clear once truncated to WIDTH bits.
    assign unused_s  = dvd_abs_s.mag[WIDTH] ^ dsr_abs_s.mag[WIDTH];

    mips_cpu_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .shifted_rem (                {rem_r, dvd_r[WIDTH-1]}),
        .divisor_mag (                dsr_r),
        .next_rem    (                next_rem_s),
        .q_bit       (                q_bit_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: CALC runs until the counter reaches its last step.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (count_r == CW'(1)) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = CALC;
                end
            end
            FIX:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and registered sign-corrected results.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_r       <= {WIDTH{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            dsr_r       <= {WIDTH{1'b0}};
            count_r     <= {CW{1'b0}};
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            div_zero_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        dvd_r      <= dvd_abs_s.mag[WIDTH-1:0];
                        dsr_r      <= dsr_abs_s.mag[WIDTH-1:0];
                        rem_r      <= {WIDTH{1'b0}};
                        count_r    <= CW'(WIDTH);
                        q_neg_r    <= dvd_abs_s.sign ^ dsr_abs_s.sign;
                        r_neg_r    <= dvd_abs_s.sign;
                        div_zero_r <= (divisor == {WIDTH{1'b0}});
                        busy_r     <= 1'b1;
                    end
                end
                CALC: begin
                    // The dividend register shifts out its MSB and collects quotient bits.
                    rem_r   <= next_rem_s;
                    dvd_r   <= {dvd_r[WIDTH-2:0], q_bit_s};
                    count_r <= count_r - CW'(1);
                end
                FIX: begin
                    // Divide-by-zero reports all ones regardless of operand signs.
                    if (div_zero_r) begin
                        quotient_r <= {WIDTH{1'b1}};
                    end else if (q_neg_r) begin
                        quotient_r <= {WIDTH{1'b0}} - dvd_r;
                    end else begin
                        quotient_r <= dvd_r;
                    end
                    if (r_neg_r) begin
                        remainder_r <= {WIDTH{1'b0}} - rem_r;
                    end else begin
                        remainder_r <= rem_r;
                    end
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;

endmodule

// File: tb/tb_mips_cpu_divider.sv
// Scoreboard bench for mips_cpu_divider: directed DIV/DIVU vectors, handshake
// and reset cases, then randomised operations against a C-semantics model.
module tb_mips_cpu_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   bc;

    mips_cpu_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done: got done=1 expected no pending operation (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("done_cycle", cyc, e.due);
            end
        end
    end

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sd, sq, sr;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
            sq = sa / sd;
            sr = sa % sd;
            q  = sq[31:0];
            r  = sr[31:0];
        end
    endfunction

    // Called at a falling edge; the following rising edge accepts the operation.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input bit track);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        if (track) sb_q.push_back('{q: eq, r: er, due: cyc + 34});
    endtask

    task automatic wait_done(input int poke_at, output int busy_cycles);
        bit seen = 1'b0;
        busy_cycles = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            start = (n == poke_at);
            if (n == poke_at) begin
                dividend  = 32'h0000_0007;
                divisor   = 32'h0000_0001;
                is_signed = 1'b0;
            end else begin
                dividend  = $urandom;
                divisor   = $urandom;
            end
            if (done) seen = 1'b1;
            else if (busy) busy_cycles++;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout: got no done in 40 cycles expected done (cycle %0d)", cyc);
        end
    endtask

    initial begin
        logic [31:0] a, b, eq, er;
        logic        s;
        int          sel;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0;
        dividend = 32'h0; divisor = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_quotient", quotient, 32'h0);
        chk("reset_remainder", remainder, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // DIVU 99 / 62 with busy duration
        issue(32'h63, 32'h3E, 1'b0, 32'd1, 32'd37, 1'b1);
        wait_done(-1, bc);
        chk("busy_cycles_1", bc, 32'd33);

        // Signed truncation, back-to-back
        issue(32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
        wait_done(-1, bc);
        issue(32'h7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h1, 1'b1);
        wait_done(-1, bc);

        // Divide by zero and signed overflow
        issue(32'h1234, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
        wait_done(-1, bc);
        issue(32'hFFFF_FFFB, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        wait_done(-1, bc);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b1);
        wait_done(-1, bc);

        // Start while busy is ignored; results hold while idle
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b1);
        wait_done(10, bc);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_quotient", quotient, 32'd14);
        chk("hold_remainder", remainder, 32'd2);

        // Start accepted in the done cycle
        issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b1);
        wait_done(-1, bc);
        issue(32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1);
        wait_done(-1, bc);
        chk("busy_cycles_b2b", bc, 32'd33);

        // Reset mid-operation discards the result
        issue(32'hFFFF_FFFF, 32'h3, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_quotient", quotient, 32'h0);
        chk("abort_remainder", remainder, 32'h0);
        repeat (40) @(negedge clk);
        issue(32'hFFFF_FFFF, 32'h3, 1'b0, 32'h5555_5555, 32'h0, 1'b1);
        wait_done(-1, bc);

        // Randomised operations, issued back-to-back
        for (int i = 0; i < 1000; i++) begin
            s   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            a   = (sel == 9) ? 32'h8000_0000 : 32'($urandom);
            if (sel == 0) b = 32'h0;
            else if (sel <= 3) b = 32'($urandom_range(1, 15));
            else if (sel == 4) b = 32'hFFFF_FFFF;
            else b = 32'($urandom);
            if (sel == 2) b = 32'h0 - b;
            model(a, b, s, eq, er);
            issue(a, b, s, eq, er, 1'b1);
            wait_done(-1, bc);
        end

        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
